// File: rtl/pe_dmem_banked.sv
// Dual-port data memory: a core port that never stalls and a bus port that is held off on
// same-word write conflicts. Storage is one 8-bit bank per byte lane.
module pe_dmem_banked #(
   parameter  int DATA_WIDTH = 32,
   parameter  int ADDR_BITS  = 8,
   parameter  int OUT_REG    = 0,
   localparam int NB         = DATA_WIDTH / 8,
   localparam int OFF        = (NB > 1) ? $clog2(NB) : 0,
   localparam int BA_W       = ADDR_BITS + OFF
) (
   input  logic                  iClk,
   input  logic                  iReset_n,
   input  logic                  iBus_Valid,
   output logic                  oBus_Ready,
   input  logic [BA_W-1:0]       iBus_Address,
   input  logic                  iBus_Write_Enable,
   input  logic [NB-1:0]         iBus_Byte_Enable,
   input  logic [DATA_WIDTH-1:0] iBus_Write_Data,
   output logic [DATA_WIDTH-1:0] oBus_Read_Data,
   output logic                  oBus_Read_Valid,
   input  logic                  iCore_Valid,
   input  logic                  iAGU_DMEM_Memory_Write_Enable,
   input  logic [NB-1:0]         iAGU_DMEM_Byte_Select,
   input  logic [ADDR_BITS-1:0]  iAGU_DMEM_Address,
   input  logic [DATA_WIDTH-1:0] iAGU_DMEM_Store_Data,
   output logic [DATA_WIDTH-1:0] oDMEM_EX_Data,
   output logic [15:0]           oConflict_Count
);

   logic [ADDR_BITS-1:0]  bus_idx;
   logic                  conflict, bus_acc, bus_wr, bus_rd, core_wr, core_rd;
   logic [DATA_WIDTH-1:0] core_word, bus_word;

   assign bus_idx  = iBus_Address[OFF +: ADDR_BITS];
   assign conflict = iCore_Valid & iBus_Valid & (bus_idx == iAGU_DMEM_Address) &
                     (iAGU_DMEM_Memory_Write_Enable | iBus_Write_Enable);
   assign oBus_Ready = iBus_Valid & ~conflict;
   assign bus_acc  = oBus_Ready;
   assign bus_wr   = bus_acc & iBus_Write_Enable;
   assign bus_rd   = bus_acc & ~iBus_Write_Enable;
   assign core_wr  = iCore_Valid & iAGU_DMEM_Memory_Write_Enable;
   assign core_rd  = iCore_Valid & ~iAGU_DMEM_Memory_Write_Enable;

   if (OFF > 0) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^iBus_Address[OFF-1:0];
   end

   // Two writes in one cycle never hit the same word: that case is a conflict and the bus waits.
   for (genvar k = 0; k < NB; k++) begin : g_bank
      logic [7:0] mem_q [2**ADDR_BITS];
      always_ff @(posedge iClk) begin
         if (core_wr && iAGU_DMEM_Byte_Select[k])
            mem_q[iAGU_DMEM_Address] <= iAGU_DMEM_Store_Data[8*k +: 8];
         if (bus_wr && iBus_Byte_Enable[k])
            mem_q[bus_idx] <= iBus_Write_Data[8*k +: 8];
      end
      assign core_word[8*k +: 8] = mem_q[iAGU_DMEM_Address];
      assign bus_word[8*k +: 8]  = mem_q[bus_idx];
   end

   // Final-stage read results feeding the output registers (old data: reads sample pre-edge).
   logic                  bf_vld, cf_vld;
   logic [DATA_WIDTH-1:0] bf_dat, cf_dat;
   logic [NB-1:0]         cf_sel;

   if (OUT_REG != 0) begin : g_oreg
      logic                  b1_vld_q, c1_vld_q;
      logic [DATA_WIDTH-1:0] b1_dat_q, c1_dat_q;
      logic [NB-1:0]         c1_sel_q;
      always_ff @(posedge iClk or negedge iReset_n) begin
         if (!iReset_n) begin
            b1_vld_q <= 1'b0;
            c1_vld_q <= 1'b0;
            b1_dat_q <= '0;
            c1_dat_q <= '0;
            c1_sel_q <= '0;
         end else begin
            b1_vld_q <= bus_rd;
            c1_vld_q <= core_rd;
            if (bus_rd) b1_dat_q <= bus_word;
            if (core_rd) begin
               c1_dat_q <= core_word;
               c1_sel_q <= iAGU_DMEM_Byte_Select;
            end
         end
      end
      assign bf_vld = b1_vld_q;
      assign bf_dat = b1_dat_q;
      assign cf_vld = c1_vld_q;
      assign cf_dat = c1_dat_q;
      assign cf_sel = c1_sel_q;
   end else begin : g_noreg
      assign bf_vld = bus_rd;
      assign bf_dat = bus_word;
      assign cf_vld = core_rd;
      assign cf_dat = core_word;
      assign cf_sel = iAGU_DMEM_Byte_Select;
   end

   logic [DATA_WIDTH-1:0] rdata_q, ex_q, ex_d;
   logic                  rvld_q;
   logic [15:0]           cnt_q, cnt_d;

   always_comb begin
      ex_d = ex_q;
      for (int k = 0; k < NB; k++)
         if (cf_vld && cf_sel[k]) ex_d[8*k +: 8] = cf_dat[8*k +: 8];
      cnt_d = (conflict && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
   end

   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         rdata_q <= '0;
         rvld_q  <= 1'b0;
         ex_q    <= '0;
         cnt_q   <= '0;
      end else begin
         rvld_q <= bf_vld;
         if (bf_vld) rdata_q <= bf_dat;
         ex_q  <= ex_d;
         cnt_q <= cnt_d;
      end
   end

   assign oBus_Read_Data  = rdata_q;
   assign oBus_Read_Valid = rvld_q;
   assign oDMEM_EX_Data   = ex_q;
   assign oConflict_Count = cnt_q;

endmodule

// File: tb/tb_pe_dmem_banked.sv
// Directed bench for pe_dmem_banked (32-bit, 256 words, OUT_REG=0): stimulus pushes expected
// read results into queues, a negedge monitor pops and compares them.
module tb_pe_dmem_banked;
   logic        iClk = 1'b0, iReset_n = 1'b0;
   logic        iBus_Valid = 1'b0, iBus_Write_Enable = 1'b0;
   logic [9:0]  iBus_Address = '0;
   logic [3:0]  iBus_Byte_Enable = '0;
   logic [31:0] iBus_Write_Data = '0;
   logic        oBus_Ready, oBus_Read_Valid;
   logic [31:0] oBus_Read_Data, oDMEM_EX_Data;
   logic        iCore_Valid = 1'b0, iAGU_DMEM_Memory_Write_Enable = 1'b0;
   logic [3:0]  iAGU_DMEM_Byte_Select = '0;
   logic [7:0]  iAGU_DMEM_Address = '0;
   logic [31:0] iAGU_DMEM_Store_Data = '0;
   logic [15:0] oConflict_Count;

   pe_dmem_banked #(.DATA_WIDTH(32), .ADDR_BITS(8), .OUT_REG(0)) dut (
      .iClk(iClk), .iReset_n(iReset_n),
      .iBus_Valid(iBus_Valid), .oBus_Ready(oBus_Ready), .iBus_Address(iBus_Address),
      .iBus_Write_Enable(iBus_Write_Enable), .iBus_Byte_Enable(iBus_Byte_Enable),
      .iBus_Write_Data(iBus_Write_Data), .oBus_Read_Data(oBus_Read_Data),
      .oBus_Read_Valid(oBus_Read_Valid), .iCore_Valid(iCore_Valid),
      .iAGU_DMEM_Memory_Write_Enable(iAGU_DMEM_Memory_Write_Enable),
      .iAGU_DMEM_Byte_Select(iAGU_DMEM_Byte_Select), .iAGU_DMEM_Address(iAGU_DMEM_Address),
      .iAGU_DMEM_Store_Data(iAGU_DMEM_Store_Data), .oDMEM_EX_Data(oDMEM_EX_Data),
      .oConflict_Count(oConflict_Count));

   always #5 iClk = ~iClk;

   typedef struct { int due; logic [31:0] val; } cexp_t;
   cexp_t       cq[$];
   logic [31:0] bq[$];
   int checks = 0, errors = 0, cyc = 0;

   always @(posedge iClk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: bus results on each Valid pulse, core results on their due cycle.
   always @(negedge iClk) begin
      if (iReset_n) begin
         if (oBus_Read_Valid) begin
            if (bq.size() == 0) chk("bus_unexpected_valid", 32'd1, 32'd0);
            else chk("bus_rdata", oBus_Read_Data, bq.pop_front());
         end
         if (cq.size() > 0 && cq[0].due == cyc) chk("core_rdata", oDMEM_EX_Data, cq.pop_front().val);
         else if (cq.size() > 0 && cq[0].due < cyc) begin
            chk("core_missed", 32'd1, 32'd0);
            void'(cq.pop_front());
         end
      end
   end

   // One cycle on both ports; checks Ready and queues the expected read results.
   task automatic step(input logic cv, input logic cw, input logic [3:0] cs, input logic [7:0] ca,
                       input logic [31:0] cd, input logic bv, input logic bw, input logic [3:0] be,
                       input logic [9:0] ba, input logic [31:0] bd, input logic exp_rdy,
                       input logic [31:0] exp_core, input logic [31:0] exp_bus);
      cexp_t e;
      iCore_Valid = cv; iAGU_DMEM_Memory_Write_Enable = cw; iAGU_DMEM_Byte_Select = cs;
      iAGU_DMEM_Address = ca; iAGU_DMEM_Store_Data = cd;
      iBus_Valid = bv; iBus_Write_Enable = bw; iBus_Byte_Enable = be;
      iBus_Address = ba; iBus_Write_Data = bd;
      #1;
      chk("bus_ready", {31'd0, oBus_Ready}, {31'd0, exp_rdy});
      if (cv && !cw) begin e.due = cyc + 1; e.val = exp_core; cq.push_back(e); end
      if (bv && !bw && exp_rdy) bq.push_back(exp_bus);
      @(posedge iClk); #1;
      iCore_Valid = 1'b0; iBus_Valid = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge iClk);
      @(negedge iClk);
      chk("rst_rdata", oBus_Read_Data, 32'd0);
      chk("rst_rvalid", {31'd0, oBus_Read_Valid}, 32'd0);
      chk("rst_ex", oDMEM_EX_Data, 32'd0);
      chk("rst_count", {16'd0, oConflict_Count}, 32'd0);
      iReset_n = 1'b1;
      @(posedge iClk); #1;

      // Bus write/read word 4
      step(0,0,4'h0,8'd0,32'h0, 1,1,4'hF,10'h010,32'hA5A5A5A5, 1, 32'h0, 32'h0);
      step(0,0,4'h0,8'd0,32'h0, 1,0,4'h0,10'h010,32'h0,        1, 32'h0, 32'hA5A5A5A5);
      // Core partial write, then full core read
      step(1,1,4'b0101,8'd4,32'h11223344, 0,0,4'h0,10'h0,32'h0, 0, 32'h0, 32'h0);
      step(1,0,4'b1111,8'd4,32'h0,        0,0,4'h0,10'h0,32'h0, 0, 32'hA522A544, 32'h0);

      // Write-write conflict on word 7: bus stalls one cycle, then its data wins
      step(1,1,4'hF,8'd7,32'h0BADF00D, 1,1,4'hF,10'h01C,32'hCAFEBABE, 0, 32'h0, 32'h0);
      chk("conflict_count", {16'd0, oConflict_Count}, 32'd1);
      step(0,0,4'h0,8'd0,32'h0, 1,1,4'hF,10'h01C,32'hCAFEBABE, 1, 32'h0, 32'h0);
      step(0,0,4'h0,8'd0,32'h0, 1,0,4'h0,10'h01C,32'h0,        1, 32'h0, 32'hCAFEBABE);

      // Core lane-select read merges into held EX data
      step(0,0,4'h0,8'd0,32'h0, 1,1,4'hF,10'h014,32'hDEADBEEF, 1, 32'h0, 32'h0);
      step(1,0,4'hF,8'd5,32'h0, 0,0,4'h0,10'h0,32'h0,          0, 32'hDEADBEEF, 32'h0);
      step(0,0,4'h0,8'd0,32'h0, 1,1,4'hF,10'h00C,32'h12345678, 1, 32'h0, 32'h0);
      step(1,0,4'b0011,8'd3,32'h0, 0,0,4'h0,10'h0,32'h0,       0, 32'hDEAD5678, 32'h0);

      // Byte enables: mask 0 changes nothing, mask 1000 touches the top lane only
      step(0,0,4'h0,8'd0,32'h0, 1,1,4'b0000,10'h00C,32'hAABBCCDD, 1, 32'h0, 32'h0);
      step(0,0,4'h0,8'd0,32'h0, 1,1,4'b1000,10'h00C,32'hAABBCCDD, 1, 32'h0, 32'h0);

      // Back-to-back bus reads, in order
      step(0,0,4'h0,8'd0,32'h0, 1,0,4'h0,10'h010,32'h0, 1, 32'h0, 32'hA522A544);
      step(0,0,4'h0,8'd0,32'h0, 1,0,4'h0,10'h01C,32'h0, 1, 32'h0, 32'hCAFEBABE);
      step(0,0,4'h0,8'd0,32'h0, 1,0,4'h0,10'h00C,32'h0, 1, 32'h0, 32'hAA345678);

      // Writes to different words in one cycle both commit; same-word reads both complete
      step(1,1,4'hF,8'd10,32'h10101010, 1,1,4'hF,10'h024,32'h99999999, 1, 32'h0, 32'h0);
      step(1,0,4'hF,8'd9,32'h0, 1,0,4'h0,10'h028,32'h0, 1, 32'h99999999, 32'h10101010);
      step(1,0,4'hF,8'd4,32'h0, 1,0,4'h0,10'h010,32'h0, 1, 32'hA522A544, 32'hA522A544);
      chk("count_stable", {16'd0, oConflict_Count}, 32'd1);

      // Saturation of the conflict counter
      iCore_Valid = 1'b1; iAGU_DMEM_Memory_Write_Enable = 1'b1; iAGU_DMEM_Byte_Select = 4'hF;
      iAGU_DMEM_Address = 8'd20; iAGU_DMEM_Store_Data = 32'h55;
      iBus_Valid = 1'b1; iBus_Write_Enable = 1'b0; iBus_Address = 10'h050;
      repeat (70000) @(posedge iClk);
      #1;
      chk("sat_ready", {31'd0, oBus_Ready}, 32'd0);
      chk("sat_count", {16'd0, oConflict_Count}, 32'h0000FFFF);
      iCore_Valid = 1'b0; iBus_Valid = 1'b0;
      @(posedge iClk); #1;

      // Reset right after a bus read is accepted discards it
      iBus_Valid = 1'b1; iBus_Write_Enable = 1'b0; iBus_Address = 10'h010;
      @(posedge iClk); #1;
      iBus_Valid = 1'b0; iReset_n = 1'b0;
      #1;
      chk("midrst_rvalid", {31'd0, oBus_Read_Valid}, 32'd0);
      chk("midrst_rdata", oBus_Read_Data, 32'd0);
      chk("midrst_ex", oDMEM_EX_Data, 32'd0);
      chk("midrst_count", {16'd0, oConflict_Count}, 32'd0);
      iBus_Valid = 1'b1; #1;
      chk("rst_ready_comb", {31'd0, oBus_Ready}, 32'd1);
      iBus_Valid = 1'b0;
      @(negedge iClk); iReset_n = 1'b1;
      repeat (4) @(posedge iClk);
      #1;
      chk("post_rst_rvalid", {31'd0, oBus_Read_Valid}, 32'd0);
      // Memory survives reset
      step(0,0,4'h0,8'd0,32'h0, 1,0,4'h0,10'h010,32'h0, 1, 32'h0, 32'hA522A544);
      repeat (3) @(posedge iClk);
      #1;
      chk("bus_queue_drained", bq.size(), 32'd0);
      chk("core_queue_drained", cq.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
